// File: rtl/wn_seq_if.sv
// Handshake and RAM bus bundle for the twiddle sequencer; widths follow LOG2N.
interface wn_seq_if #(
    parameter int LOG2N = 8
);
    localparam int IW = LOG2N - 1;
    localparam int SW = $clog2(LOG2N);

    logic          load_req;
    logic          start;
    logic          abort;
    logic          inv;
    logic          ld_valid;
    logic          ld_ready;
    logic [15:0]   ld_data;
    logic          ram_we;
    logic [15:0]   ram_addr;
    logic [15:0]   ram_wdata;
    logic [15:0]   ram_rdata;
    logic          tw_valid;
    logic          tw_ready;
    logic [15:0]   tw_data;
    logic [SW-1:0] tw_stage;
    logic [IW-1:0] tw_idx;
    logic          busy;
    logic          tbl_ok;
    logic          done;

    modport slave (
        input  load_req, start, abort, inv, ld_valid, ld_data, ram_rdata, tw_ready,
        output ld_ready, ram_we, ram_addr, ram_wdata, tw_valid, tw_data, tw_stage,
               tw_idx, busy, tbl_ok, done
    );

    modport master (
        output load_req, start, abort, inv, ld_valid, ld_data, ram_rdata, tw_ready,
        input  ld_ready, ram_we, ram_addr, ram_wdata, tw_valid, tw_data, tw_stage,
               tw_idx, busy, tbl_ok, done
    );
endinterface

// File: rtl/wn_seq.sv
// FFT twiddle sequencer: loads an N/2-word table into external RAM, then streams twiddles stage by stage.
// Latency: first tw word registered 1 cycle after start; RAM read is combinational.
// Backpressure: tw word held until tw_ready, next word follows with no bubble. WN_CONJ_EN: conjugate when inv=1.
module wn_seq #(
    parameter int LOG2N = 8
) (
    input  logic    clk,
    input  logic    rst_n,
    wn_seq_if.slave bus
);
    localparam int IW = LOG2N - 1;
    localparam int SW = $clog2(LOG2N);
    localparam logic [SW:0]   SH_MAX   = (SW+1)'(IW);
    localparam logic [SW-1:0] LAST_STG = SW'(LOG2N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    r_state;
    logic [IW-1:0] r_wcnt;
    logic [SW-1:0] r_s;
    logic [IW-1:0] r_b;
    logic          r_tbl_ok;
    logic          r_tw_valid;
    logic [15:0]   r_tw_data;
    logic [SW-1:0] r_tw_stage;
    logic [IW-1:0] r_tw_idx;

    logic          w_ld_hs;
    logic          w_tw_last;
    logic [IW-1:0] w_mask;
    logic [SW:0]   w_sh;
    logic [15:0]   w_masked;
    logic [15:0]   w_run_addr;
    logic [15:0]   w_tw_next;

    // r_s/r_b address the word that follows the one currently presented on tw_*.
    assign w_mask     = ~({IW{1'b1}} << r_s);
    assign w_sh       = SH_MAX - {1'b0, r_s};
    assign w_masked   = {{(16-IW){1'b0}}, r_b & w_mask};
    assign w_run_addr = w_masked << w_sh;

    assign w_ld_hs   = (r_state == S_LOAD) && bus.ld_valid;
    assign w_tw_last = (r_tw_stage == LAST_STG) && (r_tw_idx == {IW{1'b1}});

`ifdef WN_CONJ_EN
    logic r_inv;
    logic w_inv_now;

    function automatic logic [15:0] f_conj(input logic [15:0] d);
        logic [7:0] im;
        im = (d[7:0] == 8'h80) ? 8'h7F : (~d[7:0] + 8'd1);
        return {d[15:8], im};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_inv <= 1'b0;
        else if (r_state == S_IDLE && !bus.load_req && bus.start && r_tbl_ok)
            r_inv <= bus.inv;
    end

    assign w_inv_now = (r_state == S_IDLE) ? bus.inv : r_inv;
    assign w_tw_next = w_inv_now ? f_conj(bus.ram_rdata) : bus.ram_rdata;
`else
    assign w_tw_next = bus.ram_rdata;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wcnt     <= '0;
            r_s        <= '0;
            r_b        <= '0;
            r_tbl_ok   <= 1'b0;
            r_tw_valid <= 1'b0;
            r_tw_data  <= '0;
            r_tw_stage <= '0;
            r_tw_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.load_req) begin
                        r_state  <= S_LOAD;
                        r_wcnt   <= '0;
                        r_tbl_ok <= 1'b0;
                    end else if (bus.start && r_tbl_ok) begin
                        // ram_addr is 0 in IDLE, which is exactly the (s=0,b=0) word.
                        r_state    <= S_RUN;
                        r_tw_valid <= 1'b1;
                        r_tw_data  <= w_tw_next;
                        r_tw_stage <= '0;
                        r_tw_idx   <= '0;
                        r_s        <= '0;
                        r_b        <= IW'(1);
                    end
                end
                S_LOAD: begin
                    if (bus.abort) begin
                        r_state  <= S_IDLE;
                        r_tbl_ok <= 1'b0;
                    end else if (w_ld_hs) begin
                        r_wcnt <= r_wcnt + 1'b1;
                        if (r_wcnt == {IW{1'b1}}) begin
                            r_state  <= S_IDLE;
                            r_tbl_ok <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.abort) begin
                        r_state    <= S_IDLE;
                        r_tw_valid <= 1'b0;
                    end else if (bus.tw_ready) begin
                        if (w_tw_last) begin
                            r_state    <= S_DONE;
                            r_tw_valid <= 1'b0;
                        end else begin
                            r_tw_data  <= w_tw_next;
                            r_tw_stage <= r_s;
                            r_tw_idx   <= r_b;
                            r_b        <= r_b + 1'b1;
                            if (r_b == {IW{1'b1}})
                                r_s <= r_s + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.ram_addr = '0;
        case (r_state)
            S_LOAD:  bus.ram_addr = {{(16-IW){1'b0}}, r_wcnt};
            S_RUN:   bus.ram_addr = w_run_addr;
            default: bus.ram_addr = '0;
        endcase
    end

    assign bus.ld_ready  = (r_state == S_LOAD);
    assign bus.ram_we    = w_ld_hs;
    assign bus.ram_wdata = w_ld_hs ? bus.ld_data : 16'h0000;
    assign bus.tw_valid  = r_tw_valid;
    assign bus.tw_data   = r_tw_data;
    assign bus.tw_stage  = r_tw_stage;
    assign bus.tw_idx    = r_tw_idx;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.tbl_ok    = r_tbl_ok;
    assign bus.done      = (r_state == S_DONE);
endmodule

// File: tb/tb_wn_seq.sv
// Self-checking bench for wn_seq: directed vectors plus randomized backpressure against a table-lookup model.
module tb_wn_seq;
    localparam int LOG2N = 8;
    localparam int HALF  = 1 << (LOG2N - 1);
    localparam int BEATS = LOG2N * HALF;
`ifdef WN_CONJ_EN
    localparam bit CONJ_EN = 1'b1;
`else
    localparam bit CONJ_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [15:0] tbl [HALF];
    logic [15:0] mem [HALF];
    logic [15:0] got [BEATS];

    typedef struct {
        int          s;
        int          b;
        logic [15:0] d;
    } vec_t;
    vec_t vt [5];

    wn_seq_if #(.LOG2N(LOG2N)) bus ();

    wn_seq #(.LOG2N(LOG2N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.ram_we) mem[bus.ram_addr[6:0]] <= bus.ram_wdata;
    assign bus.ram_rdata = mem[bus.ram_addr[6:0]];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference: stage s, butterfly b reads table entry (b mod 2^s) * 2^(LOG2N-1-s).
    function automatic logic [25:0] exp_beat(input int k, input bit inv_i);
        int s, b, a, im;
        logic [15:0] w;
        logic [2:0]  s3;
        logic [6:0]  b7;
        s = k / HALF;
        b = k % HALF;
        a = (b % (1 << s)) * (1 << (LOG2N - 1 - s));
        w = tbl[a];
        if (inv_i && CONJ_EN) begin
            im = $signed(w[7:0]);
            im = (im == -128) ? 127 : -im;
            w[7:0] = im[7:0];
        end
        s3 = s[2:0];
        b7 = b[6:0];
        return {s3, b7, w};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_tbl(input bit with_start, input bit gaps, input int abort_at);
        int n, cyc;
        bit v;
        n = 0;
        cyc = 0;
        bus.load_req = 1'b1;
        bus.start    = with_start;
        tick();
        bus.load_req = 1'b0;
        bus.start    = 1'b0;
        chk("load_entry", {bus.ld_ready, bus.tbl_ok, bus.busy, bus.tw_valid}, 4'b1010);
        while (n < HALF && cyc < 2000) begin
            if (n == abort_at) begin
                bus.abort    = 1'b1;
                bus.ld_valid = 1'b0;
                tick();
                bus.abort = 1'b0;
                chk("load_abort", {bus.busy, bus.tbl_ok, bus.ld_ready, bus.done}, 4'b0000);
                return;
            end
            v = gaps ? ($urandom_range(3) != 0) : 1'b1;
            bus.ld_valid = v;
            bus.ld_data  = tbl[n];
            #1;
            if (v) chk("ld_beat", {bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.tbl_ok},
                       {1'b1, 16'(n), tbl[n], 1'b0});
            else   chk("ld_gap_we", bus.ram_we, 1'b0);
            @(posedge clk);
            #1;
            if (v) n++;
            cyc++;
        end
        bus.ld_valid = 1'b0;
        chk("ld_count", n, HALF);
        chk("ld_end", {bus.tbl_ok, bus.busy, bus.ld_ready, bus.ram_we, bus.ram_addr}, {4'b1000, 16'h0});
    endtask

    task automatic run_seq(input bit inv_i, input int rdy_pct, input int abort_at);
        int beats, cyc;
        bit rdy, held;
        logic [25:0] cur, held_v;
        beats = 0;
        cyc   = 0;
        held  = 1'b0;
        held_v = '0;
        bus.tw_ready = 1'b0;
        bus.inv   = inv_i;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.inv   = 1'b0;
        chk("first_valid", bus.tw_valid, 1'b1);
        while (beats < BEATS && cyc < 20000) begin
            cur = {bus.tw_stage, bus.tw_idx, bus.tw_data};
            chk("run_valid", {bus.tw_valid, bus.done, bus.ram_we}, 3'b100);
            if (!bus.tw_valid) break;
            if (held) chk("hold_stable", cur, held_v);
            if (beats == abort_at) begin
                bus.abort    = 1'b1;
                bus.tw_ready = 1'b0;
                tick();
                bus.abort = 1'b0;
                chk("run_abort", {bus.tw_valid, bus.busy, bus.done, bus.tbl_ok}, 4'b0001);
                repeat (4) begin
                    tick();
                    chk("abort_no_done", {bus.done, bus.busy}, 2'b00);
                end
                return;
            end
            rdy = ($urandom_range(99) < rdy_pct);
            bus.tw_ready = rdy;
            if (rdy) begin
                chk("beat", cur, exp_beat(beats, inv_i));
                got[beats] = bus.tw_data;
                beats++;
                held = 1'b0;
            end else begin
                held   = 1'b1;
                held_v = cur;
            end
            tick();
            cyc++;
        end
        chk("beat_count", beats, BEATS);
        chk("done_pulse", {bus.done, bus.tw_valid, bus.busy}, 3'b101);
        bus.tw_ready = 1'b0;
        tick();
        chk("done_clear", {bus.done, bus.busy, bus.ram_addr}, {2'b00, 16'h0});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.load_req = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.inv      = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        bus.tw_ready = 1'b0;
        for (int i = 0; i < HALF; i++) tbl[i] = 16'h0100 + 16'(i);

        vt[0] = '{s: 0, b: 0,   d: 16'h0100};
        vt[1] = '{s: 0, b: 77,  d: 16'h0100};
        vt[2] = '{s: 7, b: 5,   d: 16'h0105};
        vt[3] = '{s: 3, b: 13,  d: 16'h0150};
        vt[4] = '{s: 5, b: 127, d: 16'h017C};

        repeat (3) tick();
        chk("rst_tw", {bus.tw_valid, bus.tw_data, bus.tw_stage, bus.tw_idx}, '0);
        chk("rst_status", {bus.done, bus.busy, bus.tbl_ok, bus.ld_ready}, 4'b0000);
        chk("rst_ram", {bus.ram_we, bus.ram_addr, bus.ram_wdata}, '0);
        rst_n = 1'b1;
        tick();

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start_no_tbl", {bus.busy, bus.tw_valid}, 2'b00);

        load_tbl(1'b1, 1'b0, 60);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start_after_abort", {bus.busy, bus.tw_valid, bus.tbl_ok}, 3'b000);

        load_tbl(1'b0, 1'b1, -1);
        run_seq(1'b0, 100, -1);
        for (int i = 0; i < 5; i++)
            chk("vec_data", got[vt[i].s * HALF + vt[i].b], vt[i].d);
        run_seq(1'b1, 60, -1);

        for (int i = 0; i < HALF; i++) tbl[i] = 16'($urandom);
        tbl[0]  = 16'h7F80;
        tbl[64] = 16'h4005;
        load_tbl(1'b0, 1'b1, -1);
        run_seq(1'b1, 70, -1);
        chk("conj_sat", got[0], CONJ_EN ? 16'h7F7F : 16'h7F80);
        chk("conj_neg", got[HALF + 1], CONJ_EN ? 16'h40FB : 16'h4005);

        run_seq(1'b0, 80, 300);

        bus.tw_ready = 1'b1;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #2;
        chk("rst_mid_run", {bus.busy, bus.tw_valid, bus.tbl_ok, bus.tw_data}, '0);
        tick();
        rst_n = 1'b1;
        bus.tw_ready = 1'b0;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start_after_rst", {bus.busy, bus.tw_valid, bus.tbl_ok}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
